swd_target_phy: RTL and testbench
=================================

Name: swd_target_phy

Overview:
- SWD target-side (responder) PHY. Runs in the system CLK domain and oversamples the host-driven SWDCLK/SWDIO.
- Decodes 8-bit request packets and drives the 3-bit ACK and any read data plus parity. Captures write data plus parity.
- Hands requests and write data to a DP/AP back end through simple valid/ready ports.
- Used as a bench/emulation target for the SWD host PHY and as a bridge endpoint.

Parameters:
- LR_ONES, 50, consecutive sampled 1s on SWDIO that constitute a line reset.
- TRN, 1, turnaround length in SWDCLK cycles (1..4).

Ports:
- CLK  in  1  system clock; must be at least 4x the SWDCLK frequency.
- RESETn  in  1  asynchronous active-low reset.
- SWDCLK  in  1  host SWD clock (asynchronous).
- SWDIN  in  1  SWDIO line as seen by the target.
- SWDOUT  out  1  SWDIO value driven by the target.
- SWDOE  out  1  target output enable.
- REQ_VALID  out  1  one-CLK pulse: valid request decoded.
- REQ_APNDP  out  1  request AP(1)/DP(0).
- REQ_RNW  out  1  request read(1)/write(0).
- REQ_ADDR  out  2  request A[3:2].
- RSP_READY  in  1  back end can accept this request (OK); if low, the target answers WAIT.
- RSP_FAULT  in  1  force FAULT ACK (priority over RSP_READY).
- RSP_RDATA  in  32  read data; must be valid while RSP_READY is high.
- WR_VALID  out  1  one-CLK pulse: write data captured.
- WR_DATA  out  32  captured write data.
- WR_PERR  out  1  write parity error (qualified by WR_VALID).
- LINE_RESET  out  1  one-CLK pulse when a line reset completes.

Behaviour:
- Synchronisation
  - SWDCLK and SWDIN each pass through a 2-flop synchroniser.
  - rise = s2 & ~s3.
  - All protocol actions occur only in CLK cycles where rise=1.
- Sampling and driving
  - Target samples SWDIN at rise.
  - Target updates SWDOUT/SWDOE in the CLK cycle after the rise that ends the previous bit, so the host sees the new bit at its next rising edge.
- Bit order: all fields LSB first. Parity is even: XOR of the covered bits.
- Reset values: SWDOE=0, SWDOUT=0, all pulses 0, WR_DATA=0, REQ_* = 0. State = RESET. Ones counter = 0.
- Ones counter
  - Increments on each sampled 1 while the target is not driving; saturates at 63.
  - Clears on a sampled 0.
  - Reaching LR_ONES in any host-driven state aborts that state and enters RESET, with no REQ_VALID/WR_VALID for the aborted transfer.
- States:
  - RESET: wait for ones >= LR_ONES, then the first sampled 0. Pulse LINE_RESET, go to IDLE.
  - IDLE: sampled 0 = idle, stay. Sampled 1 = start bit, go to REQ with bit count 0.
  - REQ: shift 7 bits: APnDP, RnW, A2, A3, parity, stop, park.
    - Valid when parity == XOR(APnDP,RnW,A2,A3), stop == 0 and park == 1. Pulse REQ_VALID in the CLK cycle after the park sample, then TRN1.
    - Otherwise go to LOCKOUT with no response and no REQ_VALID.
  - TRN1: TRN cycles, SWDOE=0.
    - In the CLK cycle after the final TRN1 rise, latch ACK: RSP_FAULT gives 100; else RSP_READY gives 001; else 010.
    - Also latch RSP_RDATA if the request is a read with OK.
    - Assert SWDOE=1 and drive ACK[0].
  - ACK: drive 3 bits.
    - Read + OK: go to RDATA.
    - Write + OK: go to TRN2W.
    - WAIT/FAULT: go to TRN2 (SWDOE=0).
  - RDATA: drive 32 data bits, then the parity bit. Then TRN2 with SWDOE=0 after the parity bit's ending rise.
  - TRN2W: TRN cycles released, then WDATA.
  - WDATA: sample 32 data bits + parity. In the CLK cycle after the parity sample: WR_DATA valid, WR_PERR = parity mismatch, pulse WR_VALID. Then IDLE.
  - TRN2: TRN cycles released, then IDLE.
  - LOCKOUT: SWDOE=0, ignore everything until a line reset, then go to RESET.
- Simultaneous events: line-reset detection has priority over the state action in the same rise.
- Async reset mid-transfer: SWDOE drops immediately, then RESET.
- Back-end contract: RSP_READY, RSP_FAULT and RSP_RDATA must be stable from REQ_VALID until the ACK latch, at least TRN SWDCLK cycles.

Test Plan:
- 52 ones, then two 0s, then request 0xA5 (read DP addr 0), RSP_READY=1, RSP_RDATA=0x2BA01477 -> LINE_RESET pulse; REQ_VALID with APNDP=0 RNW=1 ADDR=0; SWDIO carries ACK 1,0,0 then 0x2BA01477 LSB first, parity=0; SWDOE=0 after TRN.
- After line reset, request 0x81 (write DP addr 0), RSP_READY=1, host sends 0x0000001E with parity 0 -> ACK OK; WR_VALID with WR_DATA=0x1E, WR_PERR=0.
- Same write with parity bit 1 -> WR_VALID, WR_PERR=1.
- Read 0xA5 with RSP_READY=0 -> ACK 0,1,0; no data phase; IDLE after TRN. With RSP_FAULT=1 -> ACK 0,0,1.
- Request with a bad parity bit (0xA1) -> no REQ_VALID; SWDOE stays 0. A following valid request is ignored until 50 ones + 0, after which a read succeeds.
- 50 ones injected mid-WDATA -> no WR_VALID; LINE_RESET fires on the next 0. RESETn asserted during RDATA -> SWDOE=0 in the same cycle.

Source files
------------

// File: rtl/swd_target_phy_if.sv
// Back-end port bundle of the SWD target PHY: decoded requests, ACK inputs and write data.
// The PHY uses the slave modport; the DP/AP back end uses the master modport.
interface swd_target_phy_if;
  logic        REQ_VALID;
  logic        REQ_APNDP;
  logic        REQ_RNW;
  logic [1:0]  REQ_ADDR;
  logic        RSP_READY;
  logic        RSP_FAULT;
  logic [31:0] RSP_RDATA;
  logic        WR_VALID;
  logic [31:0] WR_DATA;
  logic        WR_PERR;

  modport slave (
    output REQ_VALID, REQ_APNDP, REQ_RNW, REQ_ADDR, WR_VALID, WR_DATA, WR_PERR,
    input  RSP_READY, RSP_FAULT, RSP_RDATA
  );

  modport master (
    input  REQ_VALID, REQ_APNDP, REQ_RNW, REQ_ADDR, WR_VALID, WR_DATA, WR_PERR,
    output RSP_READY, RSP_FAULT, RSP_RDATA
  );
endinterface

// File: rtl/swd_target_phy.sv
// SWD target-side PHY: oversamples SWDCLK/SWDIO in the CLK domain, decodes requests,
// answers ACK/read data and captures write data for a DP/AP back end.
module swd_target_phy #(
  parameter int LR_ONES = 50,
  parameter int TRN     = 1
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic SWDCLK,
  input  logic SWDIN,
  output logic SWDOUT,
  output logic SWDOE,
  output logic LINE_RESET,
  swd_target_phy_if.slave bus
);
  localparam logic [5:0] LR_THRESH = 6'(LR_ONES);
  localparam logic [5:0] TRN_LAST  = 6'(TRN - 1);
  localparam logic [5:0] ONES_MAX  = 6'd63;

  typedef enum logic [3:0] {
    ST_RESET, ST_IDLE, ST_REQ, ST_TRN1, ST_ACK,
    ST_RDATA, ST_TRN2W, ST_WDATA, ST_TRN2, ST_LOCKOUT
  } state_t;

  state_t      state_reg, state_next;
  logic        swdclk_s1_reg, swdclk_s2_reg, swdclk_s3_reg;
  logic        swdin_s1_reg, swdin_s2_reg;
  logic [5:0]  cnt_reg, cnt_next;
  logic [5:0]  ones_reg, ones_next;
  logic [6:0]  req_sh_reg, req_sh_next;
  logic        rnw_reg, rnw_next;
  logic [2:0]  ack_reg, ack_next;
  logic [32:0] rd_sh_reg, rd_sh_next;
  logic [32:0] wr_sh_reg, wr_sh_next;
  logic        swdout_reg, swdout_next;
  logic        swdoe_reg, swdoe_next;
  logic        line_reset_reg, line_reset_next;
  logic        req_valid_reg, req_valid_next;
  logic        req_apndp_reg, req_apndp_next;
  logic        req_rnw_reg, req_rnw_next;
  logic [1:0]  req_addr_reg, req_addr_next;
  logic        wr_valid_reg, wr_valid_next;
  logic [31:0] wr_data_reg, wr_data_next;
  logic        wr_perr_reg, wr_perr_next;

  logic        rise, din, req_ok;
  logic [6:0]  req_full;
  logic [2:0]  ack_new;

  assign rise     = swdclk_s2_reg & ~swdclk_s3_reg;
  assign din      = swdin_s2_reg;
  // Request fields as they stand once the park bit has been shifted in (APnDP at bit 0).
  assign req_full = {din, req_sh_reg[6:1]};
  assign req_ok   = (req_full[4] == ^req_full[3:0]) && !req_full[5] && req_full[6];
  assign ack_new  = bus.RSP_FAULT ? 3'b100 : (bus.RSP_READY ? 3'b001 : 3'b010);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      swdclk_s1_reg  <= 1'b0; swdclk_s2_reg <= 1'b0; swdclk_s3_reg <= 1'b0;
      swdin_s1_reg   <= 1'b0; swdin_s2_reg  <= 1'b0;
      state_reg      <= ST_RESET;
      cnt_reg        <= '0;   ones_reg     <= '0;
      req_sh_reg     <= '0;   rnw_reg      <= 1'b0;
      ack_reg        <= '0;   rd_sh_reg    <= '0;   wr_sh_reg <= '0;
      swdout_reg     <= 1'b0; swdoe_reg    <= 1'b0;
      line_reset_reg <= 1'b0; req_valid_reg <= 1'b0;
      req_apndp_reg  <= 1'b0; req_rnw_reg  <= 1'b0; req_addr_reg <= '0;
      wr_valid_reg   <= 1'b0; wr_data_reg  <= '0;   wr_perr_reg  <= 1'b0;
    end else begin
      swdclk_s1_reg  <= SWDCLK; swdclk_s2_reg <= swdclk_s1_reg; swdclk_s3_reg <= swdclk_s2_reg;
      swdin_s1_reg   <= SWDIN;  swdin_s2_reg  <= swdin_s1_reg;
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;   ones_reg     <= ones_next;
      req_sh_reg     <= req_sh_next; rnw_reg     <= rnw_next;
      ack_reg        <= ack_next;   rd_sh_reg    <= rd_sh_next; wr_sh_reg <= wr_sh_next;
      swdout_reg     <= swdout_next; swdoe_reg   <= swdoe_next;
      line_reset_reg <= line_reset_next; req_valid_reg <= req_valid_next;
      req_apndp_reg  <= req_apndp_next; req_rnw_reg <= req_rnw_next; req_addr_reg <= req_addr_next;
      wr_valid_reg   <= wr_valid_next; wr_data_reg <= wr_data_next; wr_perr_reg <= wr_perr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    ones_next       = ones_reg;
    req_sh_next     = req_sh_reg;
    rnw_next        = rnw_reg;
    ack_next        = ack_reg;
    rd_sh_next      = rd_sh_reg;
    wr_sh_next      = wr_sh_reg;
    swdout_next     = swdout_reg;
    swdoe_next      = swdoe_reg;
    line_reset_next = 1'b0;
    req_valid_next  = 1'b0;
    req_apndp_next  = req_apndp_reg;
    req_rnw_next    = req_rnw_reg;
    req_addr_next   = req_addr_reg;
    wr_valid_next   = 1'b0;
    wr_data_next    = wr_data_reg;
    wr_perr_next    = wr_perr_reg;

    if (rise) begin
      if (!swdoe_reg)
        ones_next = din ? ((ones_reg == ONES_MAX) ? ONES_MAX : ones_reg + 6'd1) : 6'd0;

      // A completed line reset wins over whatever the current state would do with this bit.
      if (state_reg != ST_RESET && !swdoe_reg && din && ones_next >= LR_THRESH) begin
        state_next = ST_RESET;
        cnt_next   = '0;
      end else begin
        case (state_reg)
          ST_RESET: if (!din && ones_reg >= LR_THRESH) begin
            line_reset_next = 1'b1;
            state_next      = ST_IDLE;
          end
          ST_IDLE: if (din) begin
            state_next = ST_REQ;
            cnt_next   = '0;
          end
          ST_REQ: begin
            req_sh_next = req_full;
            cnt_next    = cnt_reg + 6'd1;
            if (cnt_reg == 6'd6) begin
              cnt_next = '0;
              if (req_ok) begin
                req_valid_next = 1'b1;
                req_apndp_next = req_full[0];
                req_rnw_next   = req_full[1];
                req_addr_next  = {req_full[3], req_full[2]};
                rnw_next       = req_full[1];
                state_next     = ST_TRN1;
              end else begin
                state_next = ST_LOCKOUT;
              end
            end
          end
          ST_TRN1: begin
            cnt_next = cnt_reg + 6'd1;
            if (cnt_reg == TRN_LAST) begin
              ack_next    = ack_new;
              swdoe_next  = 1'b1;
              swdout_next = ack_new[0];
              cnt_next    = '0;
              state_next  = ST_ACK;
              if (rnw_reg && ack_new == 3'b001)
                rd_sh_next = {^bus.RSP_RDATA, bus.RSP_RDATA};
            end
          end
          ST_ACK: begin
            cnt_next    = cnt_reg + 6'd1;
            swdout_next = (cnt_reg == 6'd0) ? ack_reg[1] : ack_reg[2];
            if (cnt_reg == 6'd2) begin
              cnt_next = '0;
              if (ack_reg == 3'b001 && rnw_reg) begin
                swdout_next = rd_sh_reg[0];
                rd_sh_next  = {1'b0, rd_sh_reg[32:1]};
                state_next  = ST_RDATA;
              end else begin
                swdoe_next  = 1'b0;
                swdout_next = 1'b0;
                state_next  = (ack_reg == 3'b001) ? ST_TRN2W : ST_TRN2;
              end
            end
          end
          ST_RDATA: begin
            cnt_next = cnt_reg + 6'd1;
            if (cnt_reg == 6'd32) begin
              swdoe_next  = 1'b0;
              swdout_next = 1'b0;
              cnt_next    = '0;
              state_next  = ST_TRN2;
            end else begin
              swdout_next = rd_sh_reg[0];
              rd_sh_next  = {1'b0, rd_sh_reg[32:1]};
            end
          end
          ST_TRN2W: begin
            cnt_next = cnt_reg + 6'd1;
            if (cnt_reg == TRN_LAST) begin
              cnt_next   = '0;
              state_next = ST_WDATA;
            end
          end
          ST_WDATA: begin
            wr_sh_next = {din, wr_sh_reg[32:1]};
            cnt_next   = cnt_reg + 6'd1;
            if (cnt_reg == 6'd32) begin
              wr_valid_next = 1'b1;
              wr_data_next  = wr_sh_next[31:0];
              wr_perr_next  = wr_sh_next[32] ^ (^wr_sh_next[31:0]);
              cnt_next      = '0;
              state_next    = ST_IDLE;
            end
          end
          ST_TRN2: begin
            cnt_next = cnt_reg + 6'd1;
            if (cnt_reg == TRN_LAST) begin
              cnt_next   = '0;
              state_next = ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign SWDOUT        = swdout_reg;
  assign SWDOE         = swdoe_reg;
  assign LINE_RESET    = line_reset_reg;
  assign bus.REQ_VALID = req_valid_reg;
  assign bus.REQ_APNDP = req_apndp_reg;
  assign bus.REQ_RNW   = req_rnw_reg;
  assign bus.REQ_ADDR  = req_addr_reg;
  assign bus.WR_VALID  = wr_valid_reg;
  assign bus.WR_DATA   = wr_data_reg;
  assign bus.WR_PERR   = wr_perr_reg;
endmodule

// File: tb/tb_swd_target_phy.sv
// Directed bench for swd_target_phy: a bit-level SWD host model drives the pins and
// hand-computed ACK/data/pulse expectations are checked per transaction.
module tb_swd_target_phy;
  // Short line-reset threshold so a reset fits inside a 33-bit write data phase.
  localparam int LR  = 20;
  localparam int TRN = 1;

  logic CLK = 1'b0, RESETn = 1'b0, SWDCLK = 1'b0;
  logic host_drv = 1'b0, host_val = 1'b0;
  logic SWDIN, SWDOUT, SWDOE, LINE_RESET;

  int n_checks = 0, n_errors = 0;
  int req_cnt = 0, wr_cnt = 0, lr_cnt = 0, oe_cnt = 0;
  logic [3:0]  req_hdr_cap = '0;
  logic [31:0] wr_data_cap = '0;
  logic        wr_perr_cap = 1'b0;

  swd_target_phy_if be_if();

  swd_target_phy #(.LR_ONES(LR), .TRN(TRN)) dut (
    .CLK(CLK), .RESETn(RESETn), .SWDCLK(SWDCLK), .SWDIN(SWDIN),
    .SWDOUT(SWDOUT), .SWDOE(SWDOE), .LINE_RESET(LINE_RESET), .bus(be_if)
  );

  always #5 CLK = ~CLK;

  // Shared SWDIO line with a pull-up when nobody drives it.
  assign SWDIN = SWDOE ? SWDOUT : (host_drv ? host_val : 1'b1);

  always @(negedge CLK) begin
    if (be_if.REQ_VALID) begin
      req_cnt++;
      req_hdr_cap = {be_if.REQ_APNDP, be_if.REQ_RNW, be_if.REQ_ADDR};
    end
    if (be_if.WR_VALID) begin
      wr_cnt++;
      wr_data_cap = be_if.WR_DATA;
      wr_perr_cap = be_if.WR_PERR;
    end
    if (LINE_RESET) lr_cnt++;
    if (SWDOE) oe_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One SWD bit: set up data with SWDCLK low, host samples the line just before the rising edge.
  task automatic swd_cycle(input logic drv, input logic v, output logic smp);
    host_drv = drv;
    host_val = v;
    repeat (4) @(posedge CLK);
    #1 smp = SWDIN;
    SWDCLK = 1'b1;
    repeat (4) @(posedge CLK);
    #1 SWDCLK = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    logic s;
    for (int i = 0; i < n; i++) swd_cycle(1'b1, v[i], s);
  endtask

  task automatic send_ones(input int n);
    logic s;
    for (int i = 0; i < n; i++) swd_cycle(1'b1, 1'b1, s);
  endtask

  task automatic release_cycles(input int n);
    logic s;
    for (int i = 0; i < n; i++) swd_cycle(1'b0, 1'b1, s);
  endtask

  task automatic get_ack(output logic [2:0] a);
    logic s;
    for (int i = 0; i < 3; i++) begin
      swd_cycle(1'b0, 1'b1, s);
      a[i] = s;
    end
  endtask

  task automatic do_read(input string tag, input logic [7:0] req, input logic [3:0] exp_hdr,
                         input logic [2:0] exp_ack, input logic [31:0] exp_data, input logic exp_par);
    logic [2:0] ack;
    logic [31:0] d;
    logic p, s;
    int rq0;
    rq0 = req_cnt;
    d   = '0;
    p   = 1'b0;
    send_bits({56'd0, req}, 8);
    release_cycles(TRN);
    check_val({tag, "_req_valid"}, req_cnt, rq0 + 1);
    check_val({tag, "_req_hdr"}, 32'(req_hdr_cap), 32'(exp_hdr));
    get_ack(ack);
    check_val({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    if (exp_ack == 3'b001) begin
      for (int i = 0; i < 32; i++) begin
        swd_cycle(1'b0, 1'b1, s);
        d[i] = s;
      end
      swd_cycle(1'b0, 1'b1, p);
      check_val({tag, "_rdata"}, d, exp_data);
      check_val({tag, "_rpar"}, 32'(p), 32'(exp_par));
    end
    release_cycles(TRN);
    check_val({tag, "_oe_after_trn"}, 32'(SWDOE), 32'd0);
    send_bits(64'd0, 2);
    $display("read  %s req=0x%02h ack=%b data=0x%08h par=%b", tag, req, ack, d, p);
  endtask

  task automatic do_write(input string tag, input logic [31:0] data, input logic par, input logic exp_perr);
    logic [2:0] ack;
    int wr0;
    wr0 = wr_cnt;
    send_bits(64'h81, 8);
    release_cycles(TRN);
    check_val({tag, "_req_hdr"}, 32'(req_hdr_cap), 32'h0);
    get_ack(ack);
    check_val({tag, "_ack"}, 32'(ack), 32'b001);
    release_cycles(TRN);
    send_bits({31'd0, par, data}, 33);
    send_bits(64'd0, 2);
    check_val({tag, "_wr_valid"}, wr_cnt, wr0 + 1);
    check_val({tag, "_wr_data"}, wr_data_cap, data);
    check_val({tag, "_wr_perr"}, 32'(wr_perr_cap), 32'(exp_perr));
    $display("write %s data=0x%08h par=%b ack=%b perr=%b", tag, data, par, ack, wr_perr_cap);
  endtask

  initial begin
    int lr0, rq0, oe0, wr0;
    logic [2:0] ack;
    be_if.RSP_READY = 1'b1;
    be_if.RSP_FAULT = 1'b0;
    be_if.RSP_RDATA = 32'h2BA01477;

    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_swdoe",  32'(SWDOE), 32'd0);
    check_val("rst_swdout", 32'(SWDOUT), 32'd0);
    check_val("rst_lr",     32'(LINE_RESET), 32'd0);
    check_val("rst_reqv",   32'(be_if.REQ_VALID), 32'd0);
    check_val("rst_wrdata", be_if.WR_DATA, 32'd0);
    RESETn = 1'b1;
    $display("reset released");

    send_ones(52);
    send_bits(64'd0, 2);
    check_val("line_reset_1", lr_cnt, 32'd1);
    $display("line reset 52 ones lr_cnt=%0d", lr_cnt);

    do_read("rd_ok", 8'hA5, 4'b0100, 3'b001, 32'h2BA01477, 1'b0);
    do_write("wr_p0", 32'h0000001E, 1'b0, 1'b0);
    do_write("wr_p1", 32'h0000001E, 1'b1, 1'b1);

    be_if.RSP_READY = 1'b0;
    do_read("rd_wait", 8'hA5, 4'b0100, 3'b010, 32'h0, 1'b0);
    be_if.RSP_READY = 1'b1;
    be_if.RSP_FAULT = 1'b1;
    do_read("rd_fault", 8'hA5, 4'b0100, 3'b100, 32'h0, 1'b0);
    be_if.RSP_FAULT = 1'b0;

    // Bad-parity request locks the target out until a full line reset.
    rq0 = req_cnt;
    oe0 = oe_cnt;
    lr0 = lr_cnt;
    send_bits(64'hA1, 8);
    send_bits(64'd0, 2);
    send_bits(64'hA5, 8);
    release_cycles(6);
    send_bits(64'd0, 2);
    check_val("lockout_no_req", req_cnt, rq0);
    check_val("lockout_no_oe",  oe_cnt, oe0);
    send_ones(LR - 1);
    send_bits(64'd0, 1);
    check_val("lr_short_ignored", lr_cnt, lr0);
    send_ones(LR);
    send_bits(64'd0, 2);
    check_val("lr_exact", lr_cnt, lr0 + 1);
    $display("lockout recovered lr_cnt=%0d", lr_cnt);
    be_if.RSP_RDATA = 32'h00000007;
    do_read("rd_ap3", 8'h9F, 4'b1111, 3'b001, 32'h00000007, 1'b1);

    // Line reset arriving in the middle of write data.
    wr0 = wr_cnt;
    lr0 = lr_cnt;
    send_bits(64'h81, 8);
    release_cycles(TRN);
    get_ack(ack);
    check_val("abort_ack", 32'(ack), 32'b001);
    release_cycles(TRN);
    send_bits(64'd0, 10);
    send_ones(50);
    check_val("abort_no_wr", wr_cnt, wr0);
    check_val("abort_lr_wait0", lr_cnt, lr0);
    send_bits(64'd0, 2);
    check_val("abort_lr", lr_cnt, lr0 + 1);
    $display("write abort wr_cnt=%0d lr_cnt=%0d", wr_cnt, lr_cnt);

    // Asynchronous reset while read data is on the wire.
    be_if.RSP_RDATA = 32'hFFFF0000;
    send_bits(64'hA5, 8);
    release_cycles(TRN);
    get_ack(ack);
    release_cycles(4);
    check_val("oe_before_rst", 32'(SWDOE), 32'd1);
    @(posedge CLK);
    #2 RESETn = 1'b0;
    #1;
    check_val("oe_async_rst",  32'(SWDOE), 32'd0);
    check_val("out_async_rst", 32'(SWDOUT), 32'd0);
    repeat (3) @(posedge CLK);
    #1 RESETn = 1'b1;
    lr0 = lr_cnt;
    send_ones(52);
    send_bits(64'd0, 2);
    check_val("lr_after_rst", lr_cnt, lr0 + 1);
    $display("async reset in rdata, recovered lr_cnt=%0d", lr_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
